// File: rtl/dtm_pkg.sv
// Shared types and constants for the debug transport module's DMI access path.
package dtm_pkg;

   localparam int DMI_ABITS = 7;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_RSVD  = 2'd3
   } dmi_op_t;

   typedef enum logic [1:0] {
      STAT_OK     = 2'd0,
      STAT_FAILED = 2'd2,
      STAT_BUSY   = 2'd3
   } dmi_stat_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2
   } dmi_state_t;

endpackage

// File: rtl/dmi_shreg.sv
// DMI data register: parallel capture, LSB-first serial shift with tdi entering the MSB.
module dmi_shreg
   import dtm_pkg::*;
#(
   parameter int W = DMI_ABITS + 34
) (
   input  logic         tclk,
   input  logic         trst,
   input  logic         capture,
   input  logic         shift,
   input  logic         tdi,
   input  logic [W-1:0] cap_value,
   output logic [W-1:0] sr,
   output logic         tdo
);

   // Capture has precedence over shift; the caller already resolved command priority.
   always_ff @(posedge tclk) begin
      if (!trst) begin
         sr <= '0;
      end else if (capture) begin
         sr <= cap_value;
      end else if (shift) begin
         sr <= {tdi, sr[W-1:1]};
      end
   end

   assign tdo = sr[0];

endmodule

// File: rtl/dtm_dmi.sv
// DTM to DMI bridge: scans {addr, data, op} requests, drives the DMI request/response
// handshake and keeps the sticky dmistat. Define DMI_TIMEOUT_EN to add a response watchdog.
module dtm_dmi
   import dtm_pkg::*;
#(
   parameter int ABITS          = DMI_ABITS,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             tclk,
   input  logic             trst,
   input  logic             capture_dr,
   input  logic             shift_dr,
   input  logic             update_dr,
   input  logic             tdi,
   output logic             dmi_tdo,
   input  logic             dmireset,
   input  logic             dmihardreset,
   output logic [1:0]       dmistat,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [ABITS-1:0] req_addr,
   output logic [31:0]      req_data,
   output logic [1:0]       req_op,
   input  logic             rsp_valid,
   output logic             rsp_ready,
   input  logic [31:0]      rsp_data,
   input  logic [1:0]       rsp_op
);

   localparam int W = ABITS + 34;

   dmi_state_t       state_q, state_d;
   dmi_stat_t        stat_q;
   dmi_op_t          op_q;
   logic [ABITS-1:0] addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic [W-1:0]     sr;
   logic [W-1:0]     cap_value;
   logic [1:0]       cap_op;
   dmi_op_t          sr_op;
   logic             upd, cap, shf, busy, start, rsp_done, rsp_err, timeout;

   // Resolve coinciding commands: hard reset, then dmireset, update, capture, shift.
   assign upd = update_dr  & ~dmihardreset & ~dmireset;
   assign cap = capture_dr & ~dmihardreset & ~dmireset & ~update_dr;
   assign shf = shift_dr   & ~dmihardreset & ~dmireset & ~update_dr & ~capture_dr;

   assign busy     = (state_q != ST_IDLE);
   assign sr_op    = dmi_op_t'(sr[1:0]);
   assign start    = upd && !busy && (stat_q == STAT_OK) &&
                     (sr_op == OP_READ || sr_op == OP_WRITE);
   assign rsp_done = (state_q == ST_WAIT_RSP) && rsp_valid && !dmihardreset;
   assign rsp_err  = (rsp_op == 2'd2) || (rsp_op == 2'd3);

   assign cap_op    = busy ? STAT_BUSY : stat_q;
   assign cap_value = {addr_q, rdata_q, cap_op};

   dmi_shreg #(.W(W)) u_shreg (
      .tclk      (tclk),
      .trst      (trst),
      .capture   (cap),
      .shift     (shf),
      .tdi       (tdi),
      .cap_value (cap_value),
      .sr        (sr),
      .tdo       (dmi_tdo)
   );

`ifdef DMI_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;

   // Watchdog restarts on each new request and counts every cycle the FSM is outstanding.
   always_ff @(posedge tclk) begin
      if (!trst) begin
         wd_cnt <= '0;
      end else if (start) begin
         wd_cnt <= '0;
      end else if (busy) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = busy && !rsp_done && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   // Without the watchdog a transaction waits for its response indefinitely.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   // FSM state register.
   always_ff @(posedge tclk) begin
      if (!trst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs; abort and watchdog override the normal flow.
   always_comb begin
      state_d   = state_q;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_REQ;
         end
         ST_REQ: begin
            req_valid = 1'b1;
            if (req_ready) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            rsp_ready = 1'b1;
            if (rsp_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (timeout || dmihardreset) state_d = ST_IDLE;
   end

   // Request fields latch on a new request; read data returns with a READ response.
   always_ff @(posedge tclk) begin
      if (!trst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= OP_NOP;
         rdata_q <= '0;
      end else begin
         if (start) begin
            addr_q  <= sr[W-1:34];
            wdata_q <= sr[33:2];
            op_q    <= sr_op;
         end
         if (rsp_done && op_q == OP_READ) begin
            rdata_q <= rsp_data;
         end
      end
   end

   // Sticky status: busy on any DR access while outstanding, otherwise first error wins.
   always_ff @(posedge tclk) begin
      if (!trst) begin
         stat_q <= STAT_OK;
      end else if (dmihardreset || dmireset) begin
         stat_q <= STAT_OK;
      end else if ((upd || cap) && busy) begin
         stat_q <= STAT_BUSY;
      end else if (stat_q == STAT_OK) begin
         if (rsp_done && rsp_err) begin
            stat_q <= dmi_stat_t'(rsp_op);
         end else if (timeout) begin
            stat_q <= STAT_FAILED;
         end
      end
   end

   assign dmistat  = stat_q;
   assign req_addr = addr_q;
   assign req_data = wdata_q;
   assign req_op   = op_q;

endmodule

// File: tb/tb_dtm_dmi.sv
// Directed bench for dtm_dmi: reset, write, read, busy, failed, abort and (with DMI_TIMEOUT_EN) watchdog.
module tb_dtm_dmi;

   localparam int ABITS = 7;
   localparam int W     = ABITS + 34;
`ifdef DMI_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic             tclk = 1'b0;
   logic             trst, capture_dr, shift_dr, update_dr, tdi;
   logic             dmi_tdo, dmireset, dmihardreset;
   logic [1:0]       dmistat;
   logic             req_valid, req_ready;
   logic [ABITS-1:0] req_addr;
   logic [31:0]      req_data;
   logic [1:0]       req_op;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_data;
   logic [1:0]       rsp_op;

   int pass_cnt  = 0;
   int total_cnt = 0;

   dtm_dmi #(.ABITS(ABITS), .TIMEOUT_CYCLES(TO)) dut (
      .tclk(tclk), .trst(trst), .capture_dr(capture_dr), .shift_dr(shift_dr),
      .update_dr(update_dr), .tdi(tdi), .dmi_tdo(dmi_tdo), .dmireset(dmireset),
      .dmihardreset(dmihardreset), .dmistat(dmistat), .req_valid(req_valid),
      .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op)
   );

   always #5 tclk = ~tclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge tclk);
      #1;
   endtask

   // Capture, shift W bits LSB first (recording tdo), then optionally update.
   task automatic dr_scan(input logic [W-1:0] din, input bit upd, output logic [W-1:0] dout);
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      for (int i = 0; i < W; i++) begin
         shift_dr = 1'b1;
         tdi      = din[i];
         dout[i]  = dmi_tdo;
         tick();
      end
      shift_dr = 1'b0;
      tdi      = 1'b0;
      if (upd) begin
         update_dr = 1'b1;
         tick();
         update_dr = 1'b0;
      end
   endtask

   // Accept the pending request, then return one response.
   task automatic complete_txn(input logic [31:0] d, input logic [1:0] op);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = d;
      rsp_op    = op;
      tick();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_op    = 2'd0;
   endtask

   task automatic test_reset();
      logic [W-1:0] dout;
      trst = 1'b0;
      tick();
      tick();
      total_cnt++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid actual=%b required=0", req_valid); else pass_cnt++;
      total_cnt++; if (rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready actual=%b required=0", rsp_ready); else pass_cnt++;
      total_cnt++; if (dmistat !== 2'd0) $display("FAIL reset_dmistat actual=%0d required=0", dmistat); else pass_cnt++;
      total_cnt++; if (dmi_tdo !== 1'b0) $display("FAIL reset_tdo actual=%b required=0", dmi_tdo); else pass_cnt++;
      total_cnt++; if ({req_addr, req_data, req_op} !== '0) $display("FAIL reset_req_fields actual=%h required=0", {req_addr, req_data, req_op}); else pass_cnt++;
      trst = 1'b1;
      tick();
      dr_scan('0, 1'b0, dout);
      total_cnt++; if (dout !== '0) $display("FAIL reset_capture actual=%h required=0", dout); else pass_cnt++;
   endtask

   task automatic test_write();
      logic [W-1:0] dout;
      dr_scan({7'h10, 32'hDEADBEEF, 2'd2}, 1'b1, dout);
      total_cnt++; if (req_valid !== 1'b1) $display("FAIL write_req_valid actual=%b required=1", req_valid); else pass_cnt++;
      total_cnt++; if (req_addr !== 7'h10) $display("FAIL write_req_addr actual=%h required=10", req_addr); else pass_cnt++;
      total_cnt++; if (req_data !== 32'hDEADBEEF) $display("FAIL write_req_data actual=%h required=deadbeef", req_data); else pass_cnt++;
      total_cnt++; if (req_op !== 2'd2) $display("FAIL write_req_op actual=%0d required=2", req_op); else pass_cnt++;
      tick();
      total_cnt++; if ({req_valid, req_data} !== {1'b1, 32'hDEADBEEF}) $display("FAIL write_req_hold actual=%h required=1deadbeef", {req_valid, req_data}); else pass_cnt++;
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      total_cnt++; if ({req_valid, rsp_ready} !== 2'b01) $display("FAIL write_wait_rsp actual=%b required=01", {req_valid, rsp_ready}); else pass_cnt++;
      rsp_valid = 1'b1;
      rsp_data  = 32'hCAFEF00D;
      rsp_op    = 2'd0;
      tick();
      rsp_valid = 1'b0;
      total_cnt++; if ({rsp_ready, dmistat} !== 3'b000) $display("FAIL write_done actual=%b required=000", {rsp_ready, dmistat}); else pass_cnt++;
      dr_scan('0, 1'b1, dout);
      total_cnt++; if (dout !== {7'h10, 32'h0, 2'd0}) $display("FAIL write_rdata_kept actual=%h required=%h", dout, {7'h10, 32'h0, 2'd0}); else pass_cnt++;
   endtask

   task automatic test_read();
      logic [W-1:0] dout;
      dr_scan({7'h11, 32'h0, 2'd1}, 1'b1, dout);
      total_cnt++; if ({req_valid, req_addr, req_op} !== {1'b1, 7'h11, 2'd1}) $display("FAIL read_req actual=%h required=%h", {req_valid, req_addr, req_op}, {1'b1, 7'h11, 2'd1}); else pass_cnt++;
      complete_txn(32'h12345678, 2'd0);
      total_cnt++; if (dmistat !== 2'd0) $display("FAIL read_dmistat actual=%0d required=0", dmistat); else pass_cnt++;
      dr_scan('0, 1'b1, dout);
      total_cnt++; if (dout !== {7'h11, 32'h12345678, 2'd0}) $display("FAIL read_capture actual=%h required=%h", dout, {7'h11, 32'h12345678, 2'd0}); else pass_cnt++;
   endtask

   task automatic test_busy();
      logic [W-1:0] dout;
      dr_scan({7'h12, 32'h0, 2'd1}, 1'b1, dout);
      dr_scan({7'h13, 32'h55, 2'd2}, 1'b1, dout);
      total_cnt++; if (dout !== {7'h12, 32'h12345678, 2'd3}) $display("FAIL busy_capture actual=%h required=%h", dout, {7'h12, 32'h12345678, 2'd3}); else pass_cnt++;
      total_cnt++; if (dmistat !== 2'd3) $display("FAIL busy_dmistat actual=%0d required=3", dmistat); else pass_cnt++;
      total_cnt++; if ({req_valid, req_addr, req_op} !== {1'b1, 7'h12, 2'd1}) $display("FAIL busy_req_undisturbed actual=%h required=%h", {req_valid, req_addr, req_op}, {1'b1, 7'h12, 2'd1}); else pass_cnt++;
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      total_cnt++; if ({req_valid, dmistat} !== 3'b100) $display("FAIL busy_dmireset actual=%b required=100", {req_valid, dmistat}); else pass_cnt++;
      complete_txn(32'hA5A5A5A5, 2'd0);
      dr_scan('0, 1'b1, dout);
      total_cnt++; if (dout !== {7'h12, 32'hA5A5A5A5, 2'd0}) $display("FAIL busy_complete actual=%h required=%h", dout, {7'h12, 32'hA5A5A5A5, 2'd0}); else pass_cnt++;
   endtask

   task automatic test_failed();
      logic [W-1:0] dout;
      dr_scan({7'h20, 32'h0, 2'd1}, 1'b1, dout);
      complete_txn(32'h11111111, 2'd2);
      total_cnt++; if (dmistat !== 2'd2) $display("FAIL failed_dmistat actual=%0d required=2", dmistat); else pass_cnt++;
      dr_scan({7'h21, 32'h0, 2'd1}, 1'b1, dout);
      total_cnt++; if (dout[1:0] !== 2'd2) $display("FAIL failed_capture_op actual=%0d required=2", dout[1:0]); else pass_cnt++;
      tick();
      total_cnt++; if (req_valid !== 1'b0) $display("FAIL failed_blocked actual=%b required=0", req_valid); else pass_cnt++;
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      dr_scan({7'h21, 32'h0, 2'd1}, 1'b1, dout);
      total_cnt++; if ({req_valid, req_addr, dmistat} !== {1'b1, 7'h21, 2'd0}) $display("FAIL failed_after_clear actual=%h required=%h", {req_valid, req_addr, dmistat}, {1'b1, 7'h21, 2'd0}); else pass_cnt++;
      complete_txn(32'h0, 2'd0);
   endtask

   task automatic test_abort();
      logic [W-1:0] dout;
      dr_scan({7'h30, 32'h77, 2'd2}, 1'b1, dout);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      total_cnt++; if ({rsp_ready, dmistat} !== 3'b111) $display("FAIL abort_pre actual=%b required=111", {rsp_ready, dmistat}); else pass_cnt++;
      dmihardreset = 1'b1;
      tick();
      dmihardreset = 1'b0;
      total_cnt++; if ({req_valid, rsp_ready, dmistat} !== 4'b0000) $display("FAIL abort_hard actual=%b required=0000", {req_valid, rsp_ready, dmistat}); else pass_cnt++;
      rsp_valid = 1'b1;
      rsp_op    = 2'd2;
      tick();
      rsp_valid = 1'b0;
      rsp_op    = 2'd0;
      total_cnt++; if (dmistat !== 2'd0) $display("FAIL abort_late_rsp actual=%0d required=0", dmistat); else pass_cnt++;
      dr_scan({7'h31, 32'hFFFFFFFF, 2'd2}, 1'b1, dout);
      total_cnt++; if (req_valid !== 1'b1) $display("FAIL abort_req_issued actual=%b required=1", req_valid); else pass_cnt++;
      trst = 1'b0;
      tick();
      trst = 1'b1;
      total_cnt++; if ({req_valid, rsp_ready, dmistat, dmi_tdo, req_addr, req_data, req_op} !== '0) $display("FAIL abort_trst actual=%h required=0", {req_valid, rsp_ready, dmistat, dmi_tdo, req_addr, req_data, req_op}); else pass_cnt++;
      rsp_valid = 1'b1;
      rsp_op    = 2'd3;
      tick();
      rsp_valid = 1'b0;
      rsp_op    = 2'd0;
      total_cnt++; if ({rsp_ready, dmistat} !== 3'b000) $display("FAIL abort_trst_late_rsp actual=%b required=000", {rsp_ready, dmistat}); else pass_cnt++;
   endtask

`ifdef DMI_TIMEOUT_EN
   task automatic test_timeout();
      logic [W-1:0] dout;
      dr_scan({7'h40, 32'h0, 2'd1}, 1'b1, dout);
      for (int i = 0; i < 15; i++) tick();
      total_cnt++; if (req_valid !== 1'b1) $display("FAIL timeout_early actual=%b required=1", req_valid); else pass_cnt++;
      tick();
      total_cnt++; if ({req_valid, dmistat} !== 3'b010) $display("FAIL timeout_fire actual=%b required=010", {req_valid, dmistat}); else pass_cnt++;
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
   endtask
`endif

   initial begin
      trst = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
      dmireset = 1'b0; dmihardreset = 1'b0; req_ready = 1'b0;
      rsp_valid = 1'b0; rsp_data = '0; rsp_op = 2'd0;
      test_reset();
      test_write();
      test_read();
`ifdef DMI_TIMEOUT_EN
      test_timeout();
`else
      test_busy();
      test_failed();
      test_abort();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dtm_dmi.md
DTM_DMI -- requirements
Module: dtm_dmi

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width; the shift register width is ABITS+34.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit used only under the configuration macro.
REQ-003 SHALL have port tclk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port trst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port capture_dr, input, 1, TAP in CAPTURE_DR with the DMI instruction selected.
REQ-006 SHALL have port shift_dr, input, 1, TAP in SHIFT_DR with the DMI instruction selected.
REQ-007 SHALL have port update_dr, input, 1, TAP in UPDATE_DR with the DMI instruction selected.
REQ-008 SHALL have port tdi, input, 1, serial data in.
REQ-009 SHALL have port dmi_tdo, output, 1, equal to shift-register bit 0.
REQ-010 SHALL have port dmireset, input, 1, clear-sticky-status pulse.
REQ-011 SHALL have port dmihardreset, input, 1, abort-transaction pulse.
REQ-012 SHALL have port dmistat, output, 2, sticky status for dtmcs: 0 ok, 2 failed, 3 busy.
REQ-013 SHALL have ports req_valid (output, 1), req_ready (input, 1), req_addr (output, ABITS), req_data (output, 32) and req_op (output, 2), forming the request channel.
REQ-014 SHALL have ports rsp_valid (input, 1), rsp_ready (output, 1), rsp_data (input, 32) and rsp_op (input, 2; 0 ok, 2 failed, 3 busy), forming the response channel.

Function
REQ-015 Shift register layout SHALL be {addr[ABITS-1:0], data[31:0], op[1:0]}, LSB first.
REQ-016 On capture_dr, SHALL load {addr_q, rdata_q, cap_op}: cap_op = 3 if FSM not IDLE, else dmistat.
REQ-017 On shift_dr, SHALL shift right one bit per cycle, with tdi entering the MSB.
REQ-018 Priority when inputs coincide SHALL be dmihardreset > dmireset > update_dr > capture_dr > shift_dr.
REQ-019 FSM states SHALL be IDLE, REQ and WAIT_RSP.
REQ-020 In IDLE, on update_dr with dmistat==0 and op READ(1) or WRITE(2), SHALL latch addr_q/wdata/op_q and go to REQ the next cycle.
REQ-021 On update_dr with op NOP(0) or RSVD(3), or with dmistat!=0, SHALL do nothing.
REQ-022 On update_dr while not IDLE, SHALL set dmistat=3, issue no new request and leave the pending transaction undisturbed.
REQ-023 On capture_dr while not IDLE, SHALL set dmistat=3.
REQ-024 In REQ, req_valid=1 with stable addr/data/op; on req_valid&&req_ready SHALL move to WAIT_RSP.
REQ-025 In WAIT_RSP, rsp_ready=1; on rsp_valid SHALL return to IDLE.
REQ-026 On that rsp_valid, rdata_q SHALL be set to rsp_data when op_q==READ, else left unchanged.
REQ-027 On that rsp_valid, rsp_op 2 or 3 SHALL set dmistat to rsp_op, unless dmistat is already non-zero (first error wins).
REQ-028 dmireset SHALL clear dmistat to 0 and SHALL NOT disturb the FSM.
REQ-029 dmihardreset SHALL force IDLE, deassert req_valid and rsp_ready, and clear dmistat in the same edge.
REQ-030 Response latency is unbounded: the FSM SHALL wait indefinitely except under REQ-034.

Reset
REQ-031 On trst low at a rising tclk edge, SHALL set: FSM=IDLE, shift register=0, addr_q=0, rdata_q=0, op_q=0, dmistat=0, req_valid=0, rsp_ready=0, dmi_tdo=0.
REQ-032 trst low mid-transaction SHALL abandon it; a late rsp_valid after reset SHALL be ignored (rsp_ready=0).

Configuration
REQ-033 Macro DMI_TIMEOUT_EN SHALL enable a watchdog counter that is cleared on entry to REQ and incremented in REQ/WAIT_RSP.
REQ-034 With DMI_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES the block SHALL force IDLE and set dmistat=2 (if 0).
REQ-035 Without DMI_TIMEOUT_EN, no counter SHALL exist and behaviour SHALL be per REQ-030.

Structure
REQ-036 Package dtm_pkg SHALL hold dmi_op_t (NOP/READ/WRITE/RSVD), dmi_stat_t (OK=0/FAILED=2/BUSY=3), the FSM state enum, and constant DMI_ABITS=7.
REQ-037 Sub-module dmi_shreg SHALL implement the capture/shift register; FSM, sticky status and watchdog SHALL stay in dtm_dmi.

Verification
REQ-038 Write: shift addr=0x10, data=0xDEADBEEF, op=2, then update -> req_valid with req_addr=0x10, req_data=0xDEADBEEF, req_op=2; rsp_op=0 -> dmistat=0.
REQ-039 Read: update op=1 addr=0x11; rsp_data=0x12345678, rsp_op=0; next capture+shift -> out {0x11, 0x12345678, 0}.
REQ-040 Busy: update a read with req_ready held 0; capture -> op field 3, dmistat=3; second update ignored; dmireset -> dmistat=0, original request completes.
REQ-041 Failed: rsp_op=2 -> dmistat=2; next update with op=1 issues no request until dmireset.
REQ-042 Abort: dmihardreset in WAIT_RSP -> IDLE next edge, rsp_ready=0, dmistat=0; trst low mid-REQ -> all outputs 0.
REQ-043 With DMI_TIMEOUT_EN and TIMEOUT_CYCLES=16, req_ready=0 -> after 16 cycles IDLE and dmistat=2.
